// File: rtl/pacote_microondas.sv
// Shared types and constants for the microwave keypad time-entry path.
package pacote_microondas;

    typedef enum logic [1:0] {
        OCIOSO,
        FILTRO_PRESS,
        ESPERA_SOLTAR,
        FILTRO_SOLTAR
    } estado_entrada_t;

    typedef logic [3:0] digito_bcd_t;

    localparam int unsigned NUM_DIGITOS_TEMPO = 4;
    localparam digito_bcd_t SEG_DEZ_MAX       = 4'd5;
    localparam digito_bcd_t DIGITO_MAX        = 4'd9;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous keypad inputs, with a configurable reset value.
module sincronizador_2ff #(
    parameter int unsigned            LARGURA     = 1,
    parameter logic [LARGURA-1:0]     VALOR_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LARGURA-1:0] d_i,
    output logic [LARGURA-1:0] q_o
);

    logic [LARGURA-1:0] meta_q, meta_d;
    logic [LARGURA-1:0] sinc_q, sinc_d;

    always_comb begin
        meta_d = d_i;
        sinc_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= VALOR_RESET;
            sinc_q <= VALOR_RESET;
        end else begin
            meta_q <= meta_d;
            sinc_q <= sinc_d;
        end
    end

    assign q_o = sinc_q;

endmodule

// File: rtl/registro_digitos_tempo.sv
// Debounces keypad presses and shifts accepted BCD digits into a 4-digit MM:SS entry buffer.
module registro_digitos_tempo
    import pacote_microondas::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = 4,
    parameter int unsigned LARGURA_CONT    = $clog2(DEBOUNCE_CICLOS + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] codigo,
    input  logic       loadn,
    input  logic       limpar,
    input  logic       travar,
    output logic [7:0] minutos,
    output logic [7:0] segundos,
    output logic [2:0] num_digitos,
    output logic       cheio,
    output logic       tempo_valido,
    output logic       digito_valido,
    output logic       digito_rejeitado
);

    localparam logic [LARGURA_CONT-1:0] CONT_UM   = LARGURA_CONT'(1);
    localparam logic [LARGURA_CONT-1:0] CONT_ALVO = LARGURA_CONT'(DEBOUNCE_CICLOS);

    logic        loadn_s;
    digito_bcd_t codigo_s;

    // loadn resets to "pressed" so a key held through reset must be released first
    sincronizador_2ff #(
        .LARGURA    (1),
        .VALOR_RESET(1'b0)
    ) u_sinc_loadn (
        .clk(clk),
        .rst(rst),
        .d_i(loadn),
        .q_o(loadn_s)
    );

    sincronizador_2ff #(
        .LARGURA    (4),
        .VALOR_RESET(4'h0)
    ) u_sinc_codigo (
        .clk(clk),
        .rst(rst),
        .d_i(codigo),
        .q_o(codigo_s)
    );

    estado_entrada_t         estado_q, estado_d;
    logic [LARGURA_CONT-1:0] cont_q, cont_d, cont_inc;
    digito_bcd_t             cod_lat_q, cod_lat_d;
    logic [15:0]             buffer_q, buffer_d;
    logic [2:0]              num_q, num_d;
    logic                    valido_q, valido_d;
    logic                    rejeitado_q, rejeitado_d;
    logic                    aceitar;

    assign cont_inc = cont_q + CONT_UM;
    assign cheio    = (num_q == 3'(NUM_DIGITOS_TEMPO));

    always_comb begin
        estado_d  = estado_q;
        cont_d    = cont_q;
        cod_lat_d = cod_lat_q;
        aceitar   = 1'b0;
        unique case (estado_q)
            OCIOSO: begin
                if (!loadn_s) begin
                    cont_d    = CONT_UM;
                    cod_lat_d = codigo_s;
                    if (CONT_UM == CONT_ALVO) begin
                        aceitar  = 1'b1;
                        estado_d = ESPERA_SOLTAR;
                    end else begin
                        estado_d = FILTRO_PRESS;
                    end
                end
            end
            FILTRO_PRESS: begin
                if (loadn_s) begin
                    estado_d = OCIOSO;
                end else begin
                    // A code change mid-press restarts the stability window
                    if (codigo_s != cod_lat_q) begin
                        cod_lat_d = codigo_s;
                        cont_d    = CONT_UM;
                    end else begin
                        cont_d = cont_inc;
                    end
                    if (cont_d == CONT_ALVO) begin
                        aceitar  = 1'b1;
                        estado_d = ESPERA_SOLTAR;
                    end
                end
            end
            ESPERA_SOLTAR: begin
                if (loadn_s) begin
                    cont_d   = CONT_UM;
                    estado_d = (CONT_UM == CONT_ALVO) ? OCIOSO : FILTRO_SOLTAR;
                end
            end
            FILTRO_SOLTAR: begin
                if (!loadn_s) begin
                    estado_d = ESPERA_SOLTAR;
                end else begin
                    cont_d = cont_inc;
                    if (cont_d == CONT_ALVO) begin
                        estado_d = OCIOSO;
                    end
                end
            end
            default: estado_d = ESPERA_SOLTAR;
        endcase
    end

    always_comb begin
        buffer_d    = buffer_q;
        num_d       = num_q;
        valido_d    = 1'b0;
        rejeitado_d = 1'b0;
        if (limpar) begin
            buffer_d = '0;
            num_d    = '0;
        end else if (aceitar) begin
            if (travar || cheio || (cod_lat_d > DIGITO_MAX)) begin
                rejeitado_d = 1'b1;
            end else begin
                buffer_d = {buffer_q[11:0], cod_lat_d};
                num_d    = num_q + 3'd1;
                valido_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q    <= ESPERA_SOLTAR;
            cont_q      <= '0;
            cod_lat_q   <= '0;
            buffer_q    <= '0;
            num_q       <= '0;
            valido_q    <= 1'b0;
            rejeitado_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            cont_q      <= cont_d;
            cod_lat_q   <= cod_lat_d;
            buffer_q    <= buffer_d;
            num_q       <= num_d;
            valido_q    <= valido_d;
            rejeitado_q <= rejeitado_d;
        end
    end

    assign minutos          = buffer_q[15:8];
    assign segundos         = buffer_q[7:0];
    assign num_digitos      = num_q;
    assign tempo_valido     = (buffer_q != '0) && (buffer_q[7:4] <= SEG_DEZ_MAX);
    assign digito_valido    = valido_q;
    assign digito_rejeitado = rejeitado_q;

endmodule

// File: tb/tb_registro_digitos_tempo.sv
// Directed bench for registro_digitos_tempo with a run-length reference model checked every cycle.
module tb_registro_digitos_tempo;

    localparam int unsigned D = 4;

    logic       clk = 1'b0;
    logic       rst, loadn, limpar, travar;
    logic [3:0] codigo;
    logic [7:0] minutos, segundos;
    logic [2:0] num_digitos;
    logic       cheio, tempo_valido, digito_valido, digito_rejeitado;

    always #5 clk = ~clk;

    registro_digitos_tempo #(
        .DEBOUNCE_CICLOS(D)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .codigo          (codigo),
        .loadn           (loadn),
        .limpar          (limpar),
        .travar          (travar),
        .minutos         (minutos),
        .segundos        (segundos),
        .num_digitos     (num_digitos),
        .cheio           (cheio),
        .tempo_valido    (tempo_valido),
        .digito_valido   (digito_valido),
        .digito_rejeitado(digito_rejeitado)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit check_en = 1'b0;

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
        end
    endtask

    // Reference: a press is accepted once the synchronised line shows D consecutive low samples
    // of one code while armed; the model re-arms after D consecutive high samples.
    logic        m_s1, m_s2;
    logic [3:0]  m_c1, m_c2;
    bit          m_armed;
    int          m_low, m_high;
    logic [3:0]  m_code;
    logic [15:0] m_buf;
    int          m_n;
    bit          m_pv, m_pr;

    always @(posedge clk) begin : modelo
        bit aceita;
        aceita = 1'b0;
        if (rst) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_c1 = 4'h0; m_c2 = 4'h0;
            m_armed = 1'b0; m_low = 0; m_high = 0; m_code = 4'h0;
            m_buf = 16'h0; m_n = 0; m_pv = 1'b0; m_pr = 1'b0;
        end else begin
            if (m_armed) begin
                if (!m_s2) begin
                    if (m_low > 0 && m_c2 == m_code) m_low++;
                    else begin m_low = 1; m_code = m_c2; end
                    if (m_low == D) begin aceita = 1'b1; m_armed = 1'b0; m_high = 0; end
                end else m_low = 0;
            end else begin
                if (m_s2) begin
                    m_high++;
                    if (m_high == D) begin m_armed = 1'b1; m_low = 0; end
                end else m_high = 0;
            end
            m_pv = 1'b0; m_pr = 1'b0;
            if (limpar) begin
                m_buf = 16'h0; m_n = 0;
            end else if (aceita) begin
                if (travar || m_n == 4 || m_code > 9) m_pr = 1'b1;
                else begin m_buf = {m_buf[11:0], m_code}; m_n++; m_pv = 1'b1; end
            end
            m_s2 = m_s1; m_s1 = loadn;
            m_c2 = m_c1; m_c1 = codigo;
        end
    end

    int n_valido = 0;
    int n_rejeitado = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check("minutos", 32'(minutos), 32'(m_buf[15:8]));
            check("segundos", 32'(segundos), 32'(m_buf[7:0]));
            check("num_digitos", 32'(num_digitos), 32'(m_n));
            check("cheio", 32'(cheio), 32'(m_n == 4));
            check("tempo_valido", 32'(tempo_valido), 32'(m_buf != 16'h0 && m_buf[7:4] <= 4'd5));
            check("digito_valido", 32'(digito_valido), 32'(m_pv));
            check("digito_rejeitado", 32'(digito_rejeitado), 32'(m_pr));
            if (digito_valido) n_valido++;
            if (digito_rejeitado) n_rejeitado++;
        end
    end

    task automatic ciclos(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic tecla(input logic [3:0] c);
        codigo = c;
        loadn  = 1'b0;
        ciclos(8);
        loadn  = 1'b1;
        ciclos(8);
    endtask

    task automatic pulsa_limpar();
        limpar = 1'b1;
        ciclos(1);
        limpar = 1'b0;
        ciclos(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, r0;
        rst = 1'b1; loadn = 1'b1; codigo = 4'h0; limpar = 1'b0; travar = 1'b0;
        @(posedge clk);
        #1;
        check_en = 1'b1;
        ciclos(1);
        check("reset_minutos", 32'(minutos), 32'h0);
        check("reset_segundos", 32'(segundos), 32'h0);
        check("reset_num", 32'(num_digitos), 32'h0);
        check("reset_flags", 32'({cheio, tempo_valido, digito_valido, digito_rejeitado}), 32'h0);
        rst = 1'b0;
        ciclos(6);

        // 1: single press of 5, accepted D+2 cycles after the pin falls
        v0 = n_valido;
        codigo = 4'h5; loadn = 1'b0;
        ciclos(5);
        check("latencia_antes", 32'(n_valido - v0), 32'h0);
        ciclos(1);
        check("latencia_pulso", 32'(digito_valido), 32'h1);
        ciclos(2);
        loadn = 1'b1;
        ciclos(8);
        check("t1_pulsos", 32'(n_valido - v0), 32'h1);
        check("t1_segundos", 32'(segundos), 32'h05);
        check("t1_num", 32'(num_digitos), 32'h1);

        // 2: bouncing line never stays low long enough
        pulsa_limpar();
        v0 = n_valido; r0 = n_rejeitado;
        codigo = 4'h7;
        loadn = 1'b0; ciclos(2);
        loadn = 1'b1; ciclos(1);
        loadn = 1'b0; ciclos(2);
        loadn = 1'b1; ciclos(1);
        ciclos(8);
        check("t2_pulsos", 32'((n_valido - v0) + (n_rejeitado - r0)), 32'h0);
        check("t2_buffer", 32'({minutos, segundos}), 32'h0);

        // 3: fill the buffer, then a fifth key is rejected
        v0 = n_valido; r0 = n_rejeitado;
        tecla(4'h1); tecla(4'h2); tecla(4'h3); tecla(4'h0);
        check("t3_minutos", 32'(minutos), 32'h12);
        check("t3_segundos", 32'(segundos), 32'h30);
        check("t3_cheio", 32'(cheio), 32'h1);
        check("t3_tempo_valido", 32'(tempo_valido), 32'h1);
        check("t3_pulsos", 32'(n_valido - v0), 32'h4);
        tecla(4'h9);
        check("t3_rejeitado", 32'(n_rejeitado - r0), 32'h1);
        check("t3_inalterado", 32'({minutos, segundos}), 32'h1230);

        // 4: 99 seconds is not a valid time; travar and codes >9 are rejected
        pulsa_limpar();
        r0 = n_rejeitado;
        tecla(4'h9); tecla(4'h9);
        check("t4_segundos", 32'(segundos), 32'h99);
        check("t4_tempo_valido", 32'(tempo_valido), 32'h0);
        check("t4_num", 32'(num_digitos), 32'h2);
        travar = 1'b1;
        tecla(4'h4);
        travar = 1'b0;
        tecla(4'hA);
        check("t4_rejeitados", 32'(n_rejeitado - r0), 32'h2);
        check("t4_inalterado", 32'({minutos, segundos}), 32'h0099);

        // 5: limpar on the accepting edge wins over the accept
        v0 = n_valido; r0 = n_rejeitado;
        codigo = 4'h6; loadn = 1'b0;
        ciclos(5);
        limpar = 1'b1;
        ciclos(1);
        limpar = 1'b0;
        check("t5_sem_pulso", 32'({digito_valido, digito_rejeitado}), 32'h0);
        check("t5_buffer", 32'({minutos, segundos}), 32'h0);
        check("t5_num", 32'(num_digitos), 32'h0);
        ciclos(4);
        loadn = 1'b1;
        ciclos(8);
        check("t5_pulsos", 32'((n_valido - v0) + (n_rejeitado - r0)), 32'h0);
        tecla(4'h6);
        check("t5_segundos", 32'(segundos), 32'h06);

        // 6: reset mid-press; the held key is ignored until released and pressed again
        v0 = n_valido; r0 = n_rejeitado;
        codigo = 4'h3; loadn = 1'b0;
        ciclos(3);
        rst = 1'b1;
        ciclos(1);
        rst = 1'b0;
        check("t6_reset_buffer", 32'({minutos, segundos}), 32'h0);
        check("t6_reset_num", 32'(num_digitos), 32'h0);
        ciclos(10);
        check("t6_sem_captura", 32'((n_valido - v0) + (n_rejeitado - r0)), 32'h0);
        loadn = 1'b1;
        ciclos(8);
        tecla(4'h3);
        check("t6_segundos", 32'(segundos), 32'h03);
        check("t6_num", 32'(num_digitos), 32'h1);
        check("t6_tempo_valido", 32'(tempo_valido), 32'h1);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
